// File: rtl/bus_transfer_ctrl.sv
// rtl/bus_transfer_ctrl.sv - shared-bus register-transfer initiator sequencing NOE/NWE strobes
module bus_transfer_ctrl #(
    parameter int SRC_COUNT = 2,
    parameter int DST_COUNT = 2,
    parameter int SRC_W     = 1,
    parameter int DST_W     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_reqValid,
    output logic                 o_reqReady,
    input  logic [SRC_W-1:0]     i_reqSrc,
    input  logic [DST_W-1:0]     i_reqDst,
    input  logic                 i_reqUseImm,
    input  logic [7:0]           i_reqImm,
    output logic [SRC_COUNT-1:0] o_srcNOE,
    output logic [DST_COUNT-1:0] o_dstNWE,
    output logic [7:0]           o_bus,
    output logic                 o_busNOE,
    input  logic                 i_busNOE,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WRITE,
        S_RELEASE,
        S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [DST_W-1:0]   dst_q, dst_d;
    logic [7:0]         imm_q, imm_d;
    logic               use_imm_q, use_imm_d;
    logic               idx_bad;

    logic [SRC_COUNT-1:0] src_noe_d;
    logic [DST_COUNT-1:0] dst_nwe_d;
    logic [7:0]           bus_d;
    logic                 bus_noe_d;
    logic                 driving;

    assign idx_bad = (32'(i_reqDst) >= DST_COUNT) ||
                     (!i_reqUseImm && (32'(i_reqSrc) >= SRC_COUNT));

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        case (state_q)
            S_IDLE: begin
                if (i_reqValid && o_reqReady) begin
                    src_d     = i_reqSrc;
                    dst_d     = i_reqDst;
                    imm_d     = i_reqImm;
                    use_imm_d = i_reqUseImm;
                    state_d   = idx_bad ? S_ABORT : S_DRIVE;
                end
            end
            S_DRIVE:   state_d = i_busNOE ? S_ABORT : S_WRITE;
            S_WRITE:   state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            S_ABORT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Strobes are computed from the upcoming state so they appear registered in that state's cycle.
    always_comb begin
        src_noe_d = '1;
        dst_nwe_d = '1;
        bus_noe_d = 1'b1;
        bus_d     = 8'h00;
        driving   = (state_d == S_DRIVE) || (state_d == S_WRITE);
        if (driving) begin
            if (use_imm_d) begin
                bus_noe_d = 1'b0;
                bus_d     = imm_d;
            end else begin
                src_noe_d = ~(SRC_COUNT'(1) << src_d);
            end
        end
        if (state_d == S_WRITE) begin
            dst_nwe_d = ~(DST_COUNT'(1) << dst_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= 8'h00;
            use_imm_q  <= 1'b0;
            o_srcNOE   <= '1;
            o_dstNWE   <= '1;
            o_busNOE   <= 1'b1;
            o_bus      <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_reqReady <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            o_srcNOE   <= src_noe_d;
            o_dstNWE   <= dst_nwe_d;
            o_busNOE   <= bus_noe_d;
            o_bus      <= bus_d;
            o_busy     <= (state_d != S_IDLE);
            o_done     <= (state_d == S_RELEASE);
            o_err      <= (state_d == S_ABORT);
            o_reqReady <= (state_d == S_IDLE);
        end
    end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb/tb_bus_transfer_ctrl.sv - directed and random checks of bus_transfer_ctrl against a cycle-trace model
module tb_bus_transfer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [1:0] req_dst;
    logic       req_use_imm;
    logic [7:0] req_imm;
    logic [1:0] src_noe;
    logic [1:0] dst_nwe;
    logic [7:0] bus;
    logic       bus_noe;
    logic       bus_noe_in;
    logic       busy;
    logic       done;
    logic       err;
    logic       tie_high;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Tristate net: driven whenever any source or the block's own immediate is enabled.
    assign bus_noe_in = tie_high ? 1'b1 : (&src_noe & bus_noe);

    bus_transfer_ctrl #(
        .SRC_COUNT(2), .DST_COUNT(2), .SRC_W(2), .DST_W(2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_reqValid (req_valid),
        .o_reqReady (req_ready),
        .i_reqSrc   (req_src),
        .i_reqDst   (req_dst),
        .i_reqUseImm(req_use_imm),
        .i_reqImm   (req_imm),
        .o_srcNOE   (src_noe),
        .o_dstNWE   (dst_nwe),
        .o_bus      (bus),
        .o_busNOE   (bus_noe),
        .i_busNOE   (bus_noe_in),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    localparam logic [16:0] IDLE_VEC = {2'b11, 2'b11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    function automatic logic [16:0] obs_vec();
        return {src_noe, dst_nwe, bus_noe, bus, busy, done, err, req_ready};
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_fields();
        req_src     = 2'($urandom);
        req_dst     = 2'($urandom);
        req_use_imm = 1'($urandom);
        req_imm     = 8'($urandom);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after an edge with the DUT idle again.
    task automatic run_xfer(input string tag, input logic [1:0] s, input logic [1:0] d,
                            input logic ui, input logic [7:0] im, input logic th);
        logic       badi;
        logic       drv;
        int         len;
        logic [1:0] one;
        logic [1:0] es;
        logic [1:0] ed;
        one         = 2'b01;
        tie_high    = th;
        req_src     = s;
        req_dst     = d;
        req_use_imm = ui;
        req_imm     = im;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_fields();
        badi = (d >= 2) || (!ui && s >= 2);
        len  = badi ? 1 : (th ? 2 : 3);
        for (int k = 1; k <= len + 1; k++) begin
            drv = !badi && (k == 1 || (k == 2 && !th));
            es  = (drv && !ui) ? ~(one << s) : 2'b11;
            ed  = (!badi && !th && k == 2) ? ~(one << d) : 2'b11;
            chk(tag, obs_vec(),
                {es, ed, !(drv && ui), (drv && ui) ? im : 8'h00,
                 k <= len, !badi && !th && k == 3,
                 (badi && k == 1) || (!badi && th && k == 2), k > len});
            if (k <= len) begin
                req_valid = 1'($urandom);
                scramble_fields();
                @(posedge clk); #1;
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        tie_high  = 1'b0;
        scramble_fields();
        @(posedge clk);
        @(posedge clk); #1;
        chk("reset_idle", obs_vec(), IDLE_VEC);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", obs_vec(), IDLE_VEC);

        run_xfer("src1_dst0", 2'd1, 2'd0, 1'b0, 8'h00, 1'b0);
        run_xfer("imm_a5_dst1", 2'd0, 2'd1, 1'b1, 8'hA5, 1'b0);
        run_xfer("bus_undriven", 2'd0, 2'd1, 1'b0, 8'h00, 1'b1);
        run_xfer("bad_dst2", 2'd0, 2'd2, 1'b0, 8'h00, 1'b0);
        run_xfer("bad_src3", 2'd3, 2'd0, 1'b0, 8'h00, 1'b0);
        run_xfer("src_eq_dst", 2'd1, 2'd1, 1'b0, 8'h00, 1'b0);
        run_xfer("imm_ignores_src", 2'd3, 2'd0, 1'b1, 8'h3C, 1'b0);

        // Reset while the destination strobe is low.
        tie_high    = 1'b0;
        req_src     = 2'd1;
        req_dst     = 2'd0;
        req_use_imm = 1'b0;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_drive", obs_vec(), {2'b01, 2'b11, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        chk("rst_write", obs_vec(), {2'b01, 2'b10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_xfer", obs_vec(), IDLE_VEC);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_pulse", obs_vec(), IDLE_VEC);
        run_xfer("after_reset", 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_xfer("random", 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                     1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
